// File: rtl/xlr_mem_pkg.sv
// Shared types and constants for the accelerator scratchpad.
// Contents: default geometry, line / byte-enable typedefs, host FSM state
// encoding and the host stall counter width.
package xlr_mem_pkg;

    localparam int XLR_LINE_BITS       = 256;
    localparam int XLR_BE_BITS         = XLR_LINE_BITS / 8;
    localparam int HOST_STALL_CNT_W    = 16;

    typedef logic [XLR_LINE_BITS-1:0] line_t;
    typedef logic [XLR_BE_BITS-1:0]   be_t;

    typedef enum logic [0:0] {
        H_IDLE = 1'b0,
        H_RESP = 1'b1
    } host_state_e;

endpackage

// File: rtl/xlr_mem_bank.sv
// One scratchpad bank: single-port byte-enable RAM with registered read.
// The read data is captured into one of two output registers depending on
// which port issued the read, so a host access never disturbs the value the
// accelerator is holding on its own read bus.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   xlr_rd / host_rd    read strobes (mutually exclusive, muxed by the top)
//   wr, addr, wdata, be write strobe, line address, write line, byte enables
//   xlr_rdata           accelerator read register, held until next xlr_rd
//   host_rdata          host read register, loaded on host_rd
module xlr_mem_bank #(
    parameter int ADDR_BITS = 4,
    parameter int LINE_BITS = 256,
    parameter int BE_BITS   = LINE_BITS / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 xlr_rd,
    input  logic                 host_rd,
    input  logic                 wr,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [LINE_BITS-1:0] wdata,
    input  logic [BE_BITS-1:0]   be,
    output logic [LINE_BITS-1:0] xlr_rdata,
    output logic [LINE_BITS-1:0] host_rdata
);

    localparam int LINES = 1 << ADDR_BITS;

    logic [LINE_BITS-1:0] mem_q [LINES];
    logic [LINE_BITS-1:0] rd_line;
    logic [LINE_BITS-1:0] xlr_rdata_q, xlr_rdata_d;
    logic [LINE_BITS-1:0] host_rdata_q, host_rdata_d;

    // Array is intentionally not reset; writes are blocked while in reset.
    always_ff @(posedge clk) begin
        if (!rst && wr) begin
            for (int b = 0; b < BE_BITS; b++) begin
                if (be[b]) begin
                    mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Sampled before the write lands: a same-cycle read sees the old line.
    assign rd_line = mem_q[addr];

    always_comb begin
        xlr_rdata_d  = xlr_rdata_q;
        host_rdata_d = host_rdata_q;
        if (xlr_rd) begin
            xlr_rdata_d = rd_line;
        end
        if (host_rd) begin
            host_rdata_d = rd_line;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xlr_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            xlr_rdata_q  <= xlr_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign xlr_rdata  = xlr_rdata_q;
    assign host_rdata = host_rdata_q;

endmodule

// File: rtl/xlr_mem_subsys.sv
// Banked line-wide scratchpad serving the accelerator (high priority, never
// stalled) and a host preload/unload port (lower priority, one outstanding
// read).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   xlr_mem_*           per-bank accelerator address/data/be/rd/wr/rdata
//   xlr_busy            accelerator running; host access blocked
//   host_req_*          host request channel (valid/ready handshake)
//   host_rsp_*          one-cycle host read response
//   host_stall_cnt      saturating count of host valid && !ready cycles
//
// Host FSM
//   state  | meaning
//   H_IDLE | accepting requests; writes complete here, one per cycle
//   H_RESP | read response presented for one cycle; no new requests
module xlr_mem_subsys
    import xlr_mem_pkg::*;
#(
    parameter int NUM_MEMS           = 2,
    parameter int LOG2_LINES_PER_MEM = 4,
    parameter int LINE_BITS          = 256,
    parameter int BE_BITS            = LINE_BITS / 8,
    parameter int MEM_SEL_BITS       = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]   xlr_mem_addr,
    input  logic [NUM_MEMS-1:0][LINE_BITS-1:0]            xlr_mem_wdata,
    input  logic [NUM_MEMS-1:0][BE_BITS-1:0]              xlr_mem_be,
    input  logic [NUM_MEMS-1:0]                           xlr_mem_rd,
    input  logic [NUM_MEMS-1:0]                           xlr_mem_wr,
    output logic [NUM_MEMS-1:0][LINE_BITS-1:0]            xlr_mem_rdata,
    input  logic                                          xlr_busy,
    input  logic                                          host_req_valid,
    output logic                                          host_req_ready,
    input  logic                                          host_req_wr,
    input  logic [MEM_SEL_BITS-1:0]                       host_req_mem,
    input  logic [LOG2_LINES_PER_MEM-1:0]                 host_req_addr,
    input  logic [LINE_BITS-1:0]                          host_req_wdata,
    input  logic [BE_BITS-1:0]                            host_req_be,
    output logic                                          host_rsp_valid,
    output logic [LINE_BITS-1:0]                          host_rsp_rdata,
    output logic [HOST_STALL_CNT_W-1:0]                   host_stall_cnt
);

    host_state_e                       state_q, state_d;
    logic [NUM_MEMS-1:0]               rsp_hit_q, rsp_hit_d;
    logic [HOST_STALL_CNT_W-1:0]       stall_cnt_q, stall_cnt_d;

    logic [NUM_MEMS-1:0]               sel_hit;
    logic [NUM_MEMS-1:0]               acc_act;
    logic [NUM_MEMS-1:0]               host_hit;
    logic                              sel_acc_busy;
    logic                              host_fire;
    logic [NUM_MEMS-1:0][LINE_BITS-1:0] bank_host_rdata;
    logic [LINE_BITS-1:0]              rsp_data;

    // One-hot bank decode; an out-of-range selector decodes to all zeros,
    // so the request is accepted but touches no bank (read returns 0).
    always_comb begin
        sel_hit = '0;
        for (int m = 0; m < NUM_MEMS; m++) begin
            sel_hit[m] = (host_req_mem == MEM_SEL_BITS'(m));
        end
    end

    assign acc_act        = xlr_mem_rd | xlr_mem_wr;
    assign sel_acc_busy   = |(sel_hit & acc_act);
    assign host_req_ready = !rst && (state_q == H_IDLE) && !xlr_busy && !sel_acc_busy;
    assign host_fire      = host_req_valid && host_req_ready;
    assign host_hit       = sel_hit & {NUM_MEMS{host_fire}};

    always_comb begin
        state_d   = state_q;
        rsp_hit_d = rsp_hit_q;
        case (state_q)
            H_IDLE: begin
                if (host_fire && !host_req_wr) begin
                    state_d   = H_RESP;
                    rsp_hit_d = sel_hit;
                end
            end
            H_RESP:  state_d = H_IDLE;
            default: state_d = H_IDLE;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (host_req_valid && !host_req_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= H_IDLE;
            rsp_hit_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_hit_q   <= rsp_hit_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        rsp_data = '0;
        for (int m = 0; m < NUM_MEMS; m++) begin
            if (rsp_hit_q[m]) begin
                rsp_data = rsp_data | bank_host_rdata[m];
            end
        end
    end

    // Gated by rst so a reset landing in H_RESP swallows the pulse.
    assign host_rsp_valid = (state_q == H_RESP) && !rst;
    assign host_rsp_rdata = host_rsp_valid ? rsp_data : '0;
    assign host_stall_cnt = stall_cnt_q;

    // The host only reaches a bank in cycles where the accelerator leaves it
    // idle, so the accelerator request steers the mux whenever present.
    for (genvar m = 0; m < NUM_MEMS; m++) begin : g_bank
        xlr_mem_bank #(
            .ADDR_BITS (LOG2_LINES_PER_MEM),
            .LINE_BITS (LINE_BITS),
            .BE_BITS   (BE_BITS)
        ) u_bank (
            .clk        (clk),
            .rst        (rst),
            .xlr_rd     (xlr_mem_rd[m]),
            .host_rd    (host_hit[m] && !host_req_wr),
            .wr         (xlr_mem_wr[m] || (host_hit[m] && host_req_wr)),
            .addr       (acc_act[m] ? xlr_mem_addr[m]  : host_req_addr),
            .wdata      (acc_act[m] ? xlr_mem_wdata[m] : host_req_wdata),
            .be         (acc_act[m] ? xlr_mem_be[m]    : host_req_be),
            .xlr_rdata  (xlr_mem_rdata[m]),
            .host_rdata (bank_host_rdata[m])
        );
    end

endmodule

// File: tb/tb_xlr_mem_subsys.sv
module tb_xlr_mem_subsys;
    import xlr_mem_pkg::*;

    localparam int NM = 2;
    localparam int AW = 4;
    localparam int LB = 256;
    localparam int BB = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NM-1:0][AW-1:0]  xlr_mem_addr;
    logic [NM-1:0][LB-1:0]  xlr_mem_wdata;
    logic [NM-1:0][BB-1:0]  xlr_mem_be;
    logic [NM-1:0]          xlr_mem_rd;
    logic [NM-1:0]          xlr_mem_wr;
    logic [NM-1:0][LB-1:0]  xlr_mem_rdata;
    logic                   xlr_busy;
    logic                   host_req_valid;
    logic                   host_req_ready;
    logic                   host_req_wr;
    logic [0:0]             host_req_mem;
    logic [AW-1:0]          host_req_addr;
    line_t                  host_req_wdata;
    be_t                    host_req_be;
    logic                   host_rsp_valid;
    line_t                  host_rsp_rdata;
    logic [15:0]            host_stall_cnt;

    int checks   = 0;
    int failures = 0;

    xlr_mem_subsys dut (
        .clk            (clk),
        .rst            (rst),
        .xlr_mem_addr   (xlr_mem_addr),
        .xlr_mem_wdata  (xlr_mem_wdata),
        .xlr_mem_be     (xlr_mem_be),
        .xlr_mem_rd     (xlr_mem_rd),
        .xlr_mem_wr     (xlr_mem_wr),
        .xlr_mem_rdata  (xlr_mem_rdata),
        .xlr_busy       (xlr_busy),
        .host_req_valid (host_req_valid),
        .host_req_ready (host_req_ready),
        .host_req_wr    (host_req_wr),
        .host_req_mem   (host_req_mem),
        .host_req_addr  (host_req_addr),
        .host_req_wdata (host_req_wdata),
        .host_req_be    (host_req_be),
        .host_rsp_valid (host_rsp_valid),
        .host_rsp_rdata (host_rsp_rdata),
        .host_stall_cnt (host_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and registered outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xlr_idle();
        xlr_mem_rd = '0;
        xlr_mem_wr = '0;
        xlr_mem_be = '0;
    endtask

    initial begin
        logic [LB-1:0] l_a5, l_5a, l_ff, l_11, l_mix, l_c3, l_77, l_00;
        l_a5  = {32{8'hA5}};
        l_5a  = {32{8'h5A}};
        l_ff  = {32{8'hFF}};
        l_11  = {32{8'h11}};
        l_mix = {{28{8'hFF}}, {4{8'h11}}};
        l_c3  = {32{8'hC3}};
        l_77  = {32{8'h77}};
        l_00  = '0;

        rst = 1'b1;
        xlr_mem_addr = '0;
        xlr_mem_wdata = '0;
        xlr_idle();
        xlr_busy = 1'b0;
        host_req_valid = 1'b0;
        host_req_wr = 1'b0;
        host_req_mem = 1'b0;
        host_req_addr = '0;
        host_req_wdata = '0;
        host_req_be = '0;

        tick();
        tick();
        host_req_valid = 1'b1;
        #1;
        chk("reset_ready", LB'(host_req_ready), LB'(1'b0));
        chk("reset_rsp_valid", LB'(host_rsp_valid), LB'(1'b0));
        chk("reset_rdata0", xlr_mem_rdata[0], l_00);
        chk("reset_rdata1", xlr_mem_rdata[1], l_00);
        chk("reset_rsp_rdata", host_rsp_rdata, l_00);
        chk("reset_stall", LB'(host_stall_cnt), LB'(16'd0));
        host_req_valid = 1'b0;
        rst = 1'b0;

        // Accelerator writes: bank 1 line 3 = 5A, bank 0 line 3 = A5.
        xlr_mem_wr[1] = 1'b1; xlr_mem_addr[1] = 4'h3; xlr_mem_wdata[1] = l_5a; xlr_mem_be[1] = '1;
        tick();
        xlr_idle();
        xlr_mem_wr[0] = 1'b1; xlr_mem_addr[0] = 4'h3; xlr_mem_wdata[0] = l_a5; xlr_mem_be[0] = '1;
        tick();
        xlr_idle();
        xlr_mem_rd = 2'b11; xlr_mem_addr[0] = 4'h3; xlr_mem_addr[1] = 4'h3;
        tick();
        chk("xlr_rd_b0_a5", xlr_mem_rdata[0], l_a5);
        chk("xlr_rd_b1_unchanged", xlr_mem_rdata[1], l_5a);
        xlr_idle();
        tick();
        chk("xlr_rdata_hold", xlr_mem_rdata[0], l_a5);

        // Partial byte-enable write and read-before-write.
        xlr_mem_wr[0] = 1'b1; xlr_mem_addr[0] = 4'h5; xlr_mem_wdata[0] = l_ff; xlr_mem_be[0] = '1;
        tick();
        xlr_mem_rd[0] = 1'b1; xlr_mem_wdata[0] = l_11; xlr_mem_be[0] = 32'h0000_000F;
        tick();
        chk("xlr_rbw_old", xlr_mem_rdata[0], l_ff);
        xlr_mem_wr[0] = 1'b1; xlr_mem_rd[0] = 1'b0; xlr_mem_wdata[0] = l_00; xlr_mem_be[0] = '0;
        tick();
        xlr_mem_wr[0] = 1'b0; xlr_mem_rd[0] = 1'b1;
        tick();
        chk("xlr_partial_be", xlr_mem_rdata[0], l_mix);
        xlr_idle();

        // Host write bank 1 line F, then read it back.
        host_req_valid = 1'b1; host_req_wr = 1'b1; host_req_mem = 1'b1;
        host_req_addr = 4'hF; host_req_wdata = l_c3; host_req_be = '1;
        #1;
        chk("host_wr_ready", LB'(host_req_ready), LB'(1'b1));
        tick();
        host_req_wr = 1'b0;
        #1;
        chk("host_rd_ready", LB'(host_req_ready), LB'(1'b1));
        tick();
        host_req_valid = 1'b0;
        #1;
        chk("host_rsp_valid", LB'(host_rsp_valid), LB'(1'b1));
        chk("host_rsp_data", host_rsp_rdata, l_c3);
        chk("host_resp_ready_low", LB'(host_req_ready), LB'(1'b0));
        tick();
        chk("host_rsp_one_cycle", LB'(host_rsp_valid), LB'(1'b0));
        chk("stall_zero", LB'(host_stall_cnt), LB'(16'd0));

        // Host to bank 1 is not blocked by accelerator traffic on bank 0.
        xlr_mem_rd[0] = 1'b1; xlr_mem_addr[0] = 4'h0;
        host_req_valid = 1'b1; host_req_wr = 1'b1; host_req_mem = 1'b1;
        host_req_addr = 4'h0; host_req_wdata = l_77; host_req_be = '1;
        #1;
        chk("host_other_bank_ready", LB'(host_req_ready), LB'(1'b1));
        tick();
        host_req_wr = 1'b0;
        tick();
        host_req_valid = 1'b0;
        #1;
        chk("host_other_bank_rsp", host_rsp_rdata, l_77);
        tick();

        // Host read of bank 0 blocked for 3 cycles by accelerator reads.
        host_req_valid = 1'b1; host_req_wr = 1'b0; host_req_mem = 1'b0; host_req_addr = 4'h3;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("host_blocked_ready", LB'(host_req_ready), LB'(1'b0));
            tick();
        end
        xlr_idle();
        #1;
        chk("stall_three", LB'(host_stall_cnt), LB'(16'd3));
        chk("host_unblocked_ready", LB'(host_req_ready), LB'(1'b1));
        tick();
        host_req_valid = 1'b0;
        #1;
        chk("host_rd_b0_data", host_rsp_rdata, l_a5);

        // Busy rising during H_RESP: response still completes.
        tick();
        host_req_valid = 1'b1; host_req_mem = 1'b1; host_req_addr = 4'hF;
        tick();
        host_req_valid = 1'b0; xlr_busy = 1'b1;
        #1;
        chk("busy_resp_valid", LB'(host_rsp_valid), LB'(1'b1));
        chk("busy_resp_data", host_rsp_rdata, l_c3);
        tick();
        chk("busy_stall_unchanged", LB'(host_stall_cnt), LB'(16'd3));

        // Saturation: 3 + 65531 = 65534, then one more reaches FFFF and holds.
        host_req_valid = 1'b1;
        for (int i = 0; i < 65531; i++) begin
            tick();
        end
        chk("stall_pre_sat", LB'(host_stall_cnt), LB'(16'hFFFE));
        tick();
        chk("stall_sat", LB'(host_stall_cnt), LB'(16'hFFFF));
        for (int i = 0; i < 4400; i++) begin
            tick();
        end
        chk("stall_sat_hold", LB'(host_stall_cnt), LB'(16'hFFFF));

        // Reset in the response cycle, with an accelerator write that must be dropped.
        xlr_busy = 1'b0; host_req_valid = 1'b0;
        tick();
        host_req_valid = 1'b1; host_req_mem = 1'b1; host_req_addr = 4'hF;
        #1;
        chk("pre_reset_ready", LB'(host_req_ready), LB'(1'b1));
        tick();
        host_req_valid = 1'b0; rst = 1'b1;
        xlr_mem_wr[0] = 1'b1; xlr_mem_addr[0] = 4'h3; xlr_mem_wdata[0] = l_00; xlr_mem_be[0] = '1;
        #1;
        chk("reset_in_resp_valid", LB'(host_rsp_valid), LB'(1'b0));
        chk("reset_in_resp_data", host_rsp_rdata, l_00);
        tick();
        chk("post_reset_rsp_valid", LB'(host_rsp_valid), LB'(1'b0));
        chk("post_reset_rdata0", xlr_mem_rdata[0], l_00);
        chk("post_reset_rdata1", xlr_mem_rdata[1], l_00);
        chk("post_reset_stall", LB'(host_stall_cnt), LB'(16'd0));
        chk("post_reset_ready", LB'(host_req_ready), LB'(1'b0));
        xlr_idle();
        rst = 1'b0;
        tick();
        xlr_mem_rd[0] = 1'b1; xlr_mem_addr[0] = 4'h3;
        tick();
        chk("reset_write_suppressed", xlr_mem_rdata[0], l_a5);
        xlr_idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
